// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit_if
//  Purpose  : Start/done handshake and operand/result bus between the main
//             control unit (master) and the sequential divider (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             div_start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             div_done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output div_start, dividend, divisor,
    input  busy, div_done, div_zero, hi_out, lo_out
  );

  modport slave (
    input  div_start, dividend, divisor,
    output busy, div_done, div_zero, hi_out, lo_out
  );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit
//  Purpose  : Sequential signed divider for MIPS DIV. Restoring division on
//             operand magnitudes, one quotient bit per cycle, then a sign-fix
//             step. Quotient goes to LO, remainder (sign of dividend) to HI.
//  Revision : 1.0  initial release
// ============================================================================
module div_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic   clock,
  input  wire logic   reset,
  div_unit_if.slave   bus
);

  localparam int                CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]     c_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_rem;      // partial remainder (magnitude)
  logic [WIDTH-1:0] r_quo;      // dividend magnitude shifting out, quotient in
  logic [WIDTH-1:0] r_dvs;      // divisor magnitude
  logic             r_neg_q;    // operand signs differ
  logic             r_neg_r;    // dividend was negative
  logic             r_dvz;      // accepted divisor was zero
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic             r_zero;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_accept;
  logic [WIDTH:0]   w_rem_sh;   // one extra bit so the compare cannot overflow
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;

  assign w_accept = (r_state == S_IDLE) && bus.div_start;

  // Operand magnitudes and one restoring-division step
  always_comb begin
    w_mag_a  = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    w_mag_b  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    w_ge     = (w_rem_sh >= {1'b0, r_dvs});
    // When w_ge holds the true difference is below 2^WIDTH, so modular
    // subtraction on the low bits gives the exact result.
    w_diff   = w_rem_sh[WIDTH-1:0] - r_dvs;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.div_start) w_next = (bus.divisor == '0) ? S_DONE : S_ITER;
      S_ITER: if (r_cnt == c_LAST) w_next = S_SIGN;
      S_SIGN: w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix and status flags
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dvz   <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_zero  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      // The completion pulse lags the DONE state by one cycle, so it always
      // lands in an IDLE cycle and can never repeat on the next cycle.
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rem   <= '0;
            r_quo   <= w_mag_a;
            r_dvs   <= w_mag_b;
            r_neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_neg_r <= bus.dividend[WIDTH-1];
            r_dvz   <= (bus.divisor == '0);
            r_cnt   <= '0;
            r_zero  <= 1'b0;
          end
        end
        S_ITER: begin
          r_rem <= w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
        end
        S_SIGN: begin
          // Most-negative / -1 wraps back to the most-negative value here.
          r_lo <= r_neg_q ? -r_quo : r_quo;
          r_hi <= r_neg_r ? -r_rem : r_rem;
        end
        S_DONE: begin
          if (r_dvz) r_zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.div_done = r_done;
  assign bus.div_zero = r_zero;
  assign bus.hi_out   = r_hi;
  assign bus.lo_out   = r_lo;

endmodule
`default_nettype wire
